mem_arbiter: RTL and testbench

Arbitrates a single-port, one-cycle-latency unified memory between the instruction-fetch and load/store stages of the RV32I core. Accepts one request per access slot, drives the memory port from registers, and returns word-aligned fetch data or sign/zero-extended, lane-aligned load data. Sits between the pipeline front/back ends and the memory model or BRAM wrapper.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundled fetch, load/store and memory-port signals of mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline/memory view.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic [1:0]  d_op;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_op, d_size, d_addr, d_wdata, m_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, d_err,
           m_req, m_we, m_addr, m_wdata, m_wstrb
  );

  modport master (
    output if_req, if_addr, d_req, d_op, d_size, d_addr, d_wdata, m_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, d_err,
           m_req, m_we, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter for a single-port, one-cycle-latency unified memory.
// Optional fetch-starvation limit is built when MEM_ARB_FAIRNESS_EN is defined.
module mem_arbiter (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] MEM_DISABLE   = 2'b00;
  localparam logic [1:0] MEM_READ_SEXT = 2'b01;
  localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
  localparam logic [1:0] MEM_WRITE     = 2'b11;
  localparam int unsigned STARVE_MAX   = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state, stateNext;
  logic        dPending, dMisaligned, forceFetch;
  logic        grantData, grantFetch;
  logic        ownerData;
  logic [1:0]  opReg, sizeReg, offReg;
  logic [3:0]  baseStrb;
  logic [31:0] shifted, loadData;
  logic        unusedIfAddrLo;

  assign unusedIfAddrLo = ^bus.if_addr[1:0];
  assign dPending = bus.d_req && (bus.d_op != MEM_DISABLE);

  always_comb begin
    dMisaligned = 1'b0;
    baseStrb    = 4'b1111;
    case (bus.d_size)
      2'd0: baseStrb = 4'b0001;
      2'd1: begin
        baseStrb    = 4'b0011;
        dMisaligned = bus.d_addr[0];
      end
      2'd2: dMisaligned = (bus.d_addr[1:0] != 2'b00);
      default: dMisaligned = 1'b1;
    endcase
  end

`ifdef MEM_ARB_FAIRNESS_EN
  logic [2:0] starveCnt;

  // Counts data grants that bypassed a waiting fetch; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset || !bus.if_req || grantFetch)
      starveCnt <= '0;
    else if (grantData && (starveCnt != 3'(STARVE_MAX)))
      starveCnt <= starveCnt + 3'd1;
  end

  assign forceFetch = (starveCnt == 3'(STARVE_MAX));
`else
  assign forceFetch = 1'b0;
`endif

  always_comb begin
    grantData  = 1'b0;
    grantFetch = 1'b0;
    if (state == IDLE) begin
      if (dPending && !(forceFetch && bus.if_req))
        grantData = 1'b1;
      else if (bus.if_req)
        grantFetch = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (grantFetch || (grantData && !dMisaligned)) stateNext = ISSUE;
      ISSUE:   stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.m_req   <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.m_wstrb <= '0;
      bus.d_err   <= 1'b0;
      ownerData   <= 1'b0;
      opReg       <= MEM_DISABLE;
      sizeReg     <= '0;
      offReg      <= '0;
    end else begin
      bus.m_req <= 1'b0;
      bus.d_err <= grantData && dMisaligned;
      if (state == ISSUE) begin
        bus.m_we    <= 1'b0;
        bus.m_wstrb <= '0;
      end
      if (grantFetch) begin
        bus.m_req   <= 1'b1;
        bus.m_we    <= 1'b0;
        bus.m_wstrb <= '0;
        bus.m_addr  <= {bus.if_addr[31:2], 2'b00};
        ownerData   <= 1'b0;
      end else if (grantData && !dMisaligned) begin
        bus.m_req  <= 1'b1;
        bus.m_we   <= (bus.d_op == MEM_WRITE);
        bus.m_addr <= {bus.d_addr[31:2], 2'b00};
        if (bus.d_op == MEM_WRITE) begin
          bus.m_wdata <= bus.d_wdata << {bus.d_addr[1:0], 3'b000};
          bus.m_wstrb <= baseStrb << bus.d_addr[1:0];
        end else begin
          bus.m_wstrb <= '0;
        end
        ownerData <= 1'b1;
        opReg     <= bus.d_op;
        sizeReg   <= bus.d_size;
        offReg    <= bus.d_addr[1:0];
      end
    end
  end

  // Lane-align the returned word, then extend according to the latched size/op.
  always_comb begin
    shifted = bus.m_rdata >> {offReg, 3'b000};
    case (sizeReg)
      2'd0: loadData = (opReg == MEM_READ_SEXT) ? {{24{shifted[7]}}, shifted[7:0]}
                                                 : {24'h000000, shifted[7:0]};
      2'd1: loadData = (opReg == MEM_READ_SEXT) ? {{16{shifted[15]}}, shifted[15:0]}
                                                 : {16'h0000, shifted[15:0]};
      default: loadData = shifted;
    endcase
  end

  always_comb begin
    bus.if_gnt   = grantFetch;
    bus.d_gnt    = grantData;
    bus.if_valid = (state == RESP) && !ownerData;
    bus.d_valid  = (state == RESP) && ownerData;
    bus.if_rdata = bus.if_valid ? bus.m_rdata : '0;
    bus.d_rdata  = (bus.d_valid && (opReg != MEM_WRITE)) ? loadData : '0;
    if (opReg == MEM_READ_ZEXT) bus.d_rdata = bus.d_valid ? loadData : '0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a byte-addressed reference memory.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam logic [1:0] MEM_DISABLE   = 2'b00;
  localparam logic [1:0] MEM_READ_SEXT = 2'b01;
  localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
  localparam logic [1:0] MEM_WRITE     = 2'b11;
  localparam int unsigned STARVE_MAX   = 3;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  // Memory serving the DUT port (word array) and independent byte-level reference.
  logic [31:0] dutMem [0:127];
  logic [7:0]  refMem [0:511];
  logic [31:0] memRdata = '0;
  logic        preWe = 1'b0;
  logic [6:0]  preIdx = '0;
  logic [31:0] preData = '0;
  int nCompared = 0;
  int nMismatched = 0;

  assign bus.m_rdata = memRdata;

  always @(posedge clk) begin
    logic [31:0] w;
    if (preWe) begin
      dutMem[preIdx] <= preData;
    end else if (bus.m_req) begin
      w = dutMem[bus.m_addr[8:2]];
      if (bus.m_we) begin
        for (int i = 0; i < 4; i++)
          if (bus.m_wstrb[i]) w[8*i +: 8] = bus.m_wdata[8*i +: 8];
        dutMem[bus.m_addr[8:2]] <= w;
      end else begin
        memRdata <= w;
      end
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic setWord(input int unsigned addr, input logic [31:0] value);
    for (int i = 0; i < 4; i++) refMem[addr + i] = value[8*i +: 8];
    @(negedge clk);
    preWe = 1'b1; preIdx = 7'(addr >> 2); preData = value;
    @(negedge clk);
    preWe = 1'b0;
  endtask

  function automatic logic [31:0] refWord(input int unsigned addr);
    int unsigned a;
    a = addr & 32'h1FC;
    return {refMem[a+3], refMem[a+2], refMem[a+1], refMem[a]};
  endfunction

  function automatic int unsigned sizeBytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] refLoad(input int unsigned addr, input logic [1:0] size,
                                          input logic [1:0] op);
    int unsigned n;
    logic [31:0] v;
    n = sizeBytes(size);
    v = '0;
    for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = refMem[addr + i];
    if (op == MEM_READ_SEXT && n < 4 && v[8*n - 1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
    return v;
  endfunction

  task automatic dropReqs();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
  endtask

  task automatic doAccess(input bit isFetch, input logic [1:0] op, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned waited;
    bit mis, isStore;
    logic gnt;
    logic [3:0] expStrb;
    int unsigned a;
    a = addr & 32'h1FF;
    isStore = !isFetch && (op == MEM_WRITE);
    mis = !isFetch && (size == 2'd3 || (size == 2'd1 && addr[0]) ||
                       (size == 2'd2 && addr[1:0] != 2'b00));
    @(negedge clk);
    if (isFetch) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.d_req = 1'b1; bus.d_op = op; bus.d_size = size; bus.d_addr = addr; bus.d_wdata = wdata;
    end
    #1;
    waited = 0;
    gnt = isFetch ? bus.if_gnt : bus.d_gnt;
    while (!gnt && waited < 8) begin
      @(negedge clk); #1;
      waited++;
      gnt = isFetch ? bus.if_gnt : bus.d_gnt;
    end
    checkVal(isFetch ? "ifGnt" : "dGnt", gnt, 1);
    checkVal("gntLatency", waited, 0);
    checkVal("otherGnt", isFetch ? bus.d_gnt : bus.if_gnt, 0);
    if (!gnt) begin
      dropReqs();
      return;
    end
    @(negedge clk);
    dropReqs();
    #1;
    if (mis) begin
      checkVal("dErr", bus.d_err, 1);
      checkVal("mReqMis", bus.m_req, 0);
      @(negedge clk); #1;
      checkVal("dValidMis", bus.d_valid, 0);
      checkVal("dErrPulse", bus.d_err, 0);
      return;
    end
    checkVal("mReq", bus.m_req, 1);
    checkVal("mAddr", bus.m_addr, addr & 32'hFFFF_FFFC);
    checkVal("mWe", bus.m_we, isStore);
    if (isStore) begin
      expStrb = '0;
      for (int unsigned i = 0; i < sizeBytes(size); i++) expStrb[(a + i) % 4] = 1'b1;
      checkVal("mWstrb", bus.m_wstrb, expStrb);
      checkVal("mWdata", bus.m_wdata, wdata << (8 * (a % 4)));
      for (int unsigned i = 0; i < sizeBytes(size); i++) refMem[a + i] = wdata[8*i +: 8];
    end
    @(negedge clk); #1;
    if (isFetch) begin
      checkVal("ifValid", bus.if_valid, 1);
      checkVal("ifRdata", bus.if_rdata, refWord(a));
      checkVal("dValidOnFetch", bus.d_valid, 0);
    end else begin
      checkVal("dValid", bus.d_valid, 1);
      checkVal("dRdata", bus.d_rdata, isStore ? 32'h0 : refLoad(a, size, op));
      checkVal("ifValidOnData", bus.if_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned grants, cyc, lastCyc, a;
    bit f;
    logic [1:0] op, sz, expG;

    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_op = MEM_DISABLE; bus.d_size = '0; bus.d_addr = '0; bus.d_wdata = '0;
    for (int unsigned i = 0; i < 128; i++) setWord(i * 4, $urandom);
    setWord(32'h8, 32'h0020_0093);
    setWord(32'h100, 32'h8001_1234);
    #1;
    checkVal("rstMReq", bus.m_req, 0);
    checkVal("rstIfValid", bus.if_valid, 0);
    checkVal("rstDValid", bus.d_valid, 0);
    checkVal("rstMAddr", bus.m_addr, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    doAccess(1'b1, MEM_DISABLE, 2'd0, 32'h8, '0);
    doAccess(1'b0, MEM_READ_SEXT, 2'd1, 32'h102, '0);
    doAccess(1'b0, MEM_READ_ZEXT, 2'd1, 32'h102, '0);
    doAccess(1'b0, MEM_WRITE, 2'd0, 32'h103, 32'h0000_00AB);
    doAccess(1'b0, MEM_READ_ZEXT, 2'd2, 32'h100, '0);
    doAccess(1'b0, MEM_READ_ZEXT, 2'd2, 32'h101, '0);
    doAccess(1'b0, MEM_READ_SEXT, 2'd3, 32'h100, '0);

    // MEM_DISABLE request must be ignored
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_op = MEM_DISABLE; bus.d_size = 2'd2; bus.d_addr = 32'h40;
    #1;
    checkVal("disableGnt", bus.d_gnt, 0);
    @(negedge clk); #1;
    checkVal("disableMReq", bus.m_req, 0);
    dropReqs();

    // Reset during ISSUE abandons the access
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_op = MEM_READ_ZEXT; bus.d_size = 2'd2; bus.d_addr = 32'h100;
    #1;
    checkVal("rstTestGnt", bus.d_gnt, 1);
    @(negedge clk);
    dropReqs();
    #1;
    checkVal("rstTestIssue", bus.m_req, 1);
    reset = 1'b1;
    @(negedge clk); #1;
    checkVal("rstAbIfValid", bus.if_valid, 0);
    checkVal("rstAbDValid", bus.d_valid, 0);
    checkVal("rstAbMReq", bus.m_req, 0);
    checkVal("rstAbMWe", bus.m_we, 0);
    checkVal("rstAbMAddr", bus.m_addr, 0);
    checkVal("rstAbDRdata", bus.d_rdata, 0);
    reset = 1'b0;
    doAccess(1'b0, MEM_READ_SEXT, 2'd0, 32'h103, '0);

    // Both requesters held: grant order
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h8;
    bus.d_req = 1'b1; bus.d_op = MEM_READ_ZEXT; bus.d_size = 2'd2; bus.d_addr = 32'h100;
    grants = 0; cyc = 0; lastCyc = 0;
    while (grants < 8 && cyc < 60) begin
      #1;
      if (bus.if_gnt || bus.d_gnt) begin
        expG = (FAIR && (grants % (STARVE_MAX + 1)) == STARVE_MAX) ? 2'b10 : 2'b01;
        checkVal("grantOrder", {bus.if_gnt, bus.d_gnt}, expG);
        if (grants > 0) checkVal("grantSpacing", cyc - lastCyc, 3);
        lastCyc = cyc;
        grants++;
      end
      @(negedge clk);
      cyc++;
    end
    checkVal("grantCount", grants, 8);
    dropReqs();
    @(negedge clk);

    // Randomized single-requester traffic
    for (int t = 0; t < 80; t++) begin
      f  = ($urandom_range(0, 9) < 3);
      op = 2'($urandom_range(1, 3));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom_range(0, 511);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & 32'h1FE;
        else if (sz == 2'd2) a = a & 32'h1FC;
      end
      doAccess(f, op, sz, a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
